// File: rtl/calc1_port_responder_if.sv
// calc1 request-port bundle: command/operands toward the responder, response/status back.
// DROP_W sizes the dropped-command counter and must match the responder instance.
interface calc1_port_responder_if #(
  parameter int DROP_W = 8
);
  logic [0:3]        req_cmd_in;
  logic [0:31]       req_data_in;
  logic [0:1]        out_resp;
  logic [0:31]       out_data;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output req_cmd_in, req_data_in,
    input  out_resp, out_data, busy, drop_cnt
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output out_resp, out_data, busy, drop_cnt
  );
endinterface

// File: rtl/calc1_port_responder.sv
// calc1 responder port: command+op1, then op2, then LATENCY execute cycles, then a 1-cycle response.
// No backpressure: commands seen while busy are discarded and counted in drop_cnt (saturating).
module calc1_port_responder #(
  parameter int LATENCY = 3,
  parameter int DROP_W  = 8
) (
  input logic                   c_clk,
  input logic                   reset,
  calc1_port_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OPND2, EXEC, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_LSH = 4'd5;
  localparam logic [0:3] CMD_RSH = 4'd6;

  state_t            r_state;
  logic [0:3]        r_cmd;
  logic [0:31]       r_op1;
  logic [0:31]       r_op2;
  logic [3:0]        r_cnt;
  logic [0:1]        r_out_resp;
  logic [0:31]       r_out_data;
  logic [DROP_W-1:0] r_drop_cnt;

  logic [32:0]       w_sum;
  logic [0:1]        w_code;
  logic [0:31]       w_res;
  logic              w_drop_hit;

  assign w_sum      = {1'b0, r_op1} + {1'b0, r_op2};
  assign w_drop_hit = (r_state != IDLE) && (bus.req_cmd_in != 4'd0);

  // Operands are stable from the OPND2 edge on, so the result is ready long before it is copied out.
  always_comb begin
    w_code = 2'd3;
    w_res  = '0;
    case (r_cmd)
      CMD_ADD: begin
        if (w_sum[32]) begin
          w_code = 2'd2;
        end else begin
          w_code = 2'd1;
          w_res  = w_sum[31:0];
        end
      end
      CMD_SUB: begin
        if (r_op2 > r_op1) begin
          w_code = 2'd2;
        end else begin
          w_code = 2'd1;
          w_res  = r_op1 - r_op2;
        end
      end
      CMD_LSH: begin
        w_code = 2'd1;
        w_res  = r_op1 << r_op2[27:31];
      end
      CMD_RSH: begin
        w_code = 2'd1;
        w_res  = r_op1 >> r_op2[27:31];
      end
      default: begin
        w_code = 2'd3;
        w_res  = '0;
      end
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cmd      <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_cnt      <= '0;
      r_out_resp <= '0;
      r_out_data <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop_hit && (r_drop_cnt != {DROP_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (bus.req_cmd_in != 4'd0) begin
            r_cmd   <= bus.req_cmd_in;
            r_op1   <= bus.req_data_in;
            r_state <= OPND2;
          end
        end
        OPND2: begin
          r_op2   <= bus.req_data_in;
          r_cnt   <= LAT_M1;
          r_state <= EXEC;
        end
        EXEC: begin
          if (r_cnt == 4'd0) begin
            r_out_resp <= w_code;
            r_out_data <= w_res;
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_out_resp <= '0;
          r_out_data <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_resp = r_out_resp;
  assign bus.out_data = r_out_data;
  assign bus.busy     = (r_state != IDLE);
  assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_calc1_port_responder.sv
// Bench for calc1_port_responder: vector table through a response scoreboard, plus drop/reset sequences.
module tb_calc1_port_responder;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic [0:3]  cmd;
  logic [0:31] dat;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  calc1_port_responder_if #(.DROP_W(8)) bus8 ();
  calc1_port_responder_if #(.DROP_W(2)) bus2 ();

  assign bus8.req_cmd_in  = cmd;
  assign bus8.req_data_in = dat;
  assign bus2.req_cmd_in  = cmd;
  assign bus2.req_data_in = dat;

  calc1_port_responder #(.LATENCY(LAT), .DROP_W(8)) dut  (.c_clk(clk), .reset(rst_n), .bus(bus8));
  calc1_port_responder #(.LATENCY(LAT), .DROP_W(2)) dut2 (.c_clk(clk), .reset(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          edge_no;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  r;
    logic [31:0] d;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every nonzero response must be one the bench expected, at the expected edge.
  always @(negedge clk) begin
    if (bus8.out_resp != 2'd0) begin
      sb_t e;
      if (sb_q.size() == 0) begin
        chk("spurious_resp", 32'(bus8.out_resp), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_code", 32'(bus8.out_resp), 32'(e.resp));
        chk("resp_data", bus8.out_data, e.data);
        chk("resp_edge", 32'(cyc), 32'(e.edge_no));
      end
    end else if (bus8.out_data != 32'd0) begin
      chk("idle_data_zero", bus8.out_data, 32'd0);
    end
  end

  task automatic run_txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] er, input logic [31:0] ed);
    int k;
    sb_t e;
    @(negedge clk); cmd = c; dat = a;
    @(negedge clk); k = cyc; cmd = 4'd0; dat = b;
    e.resp = er; e.data = ed; e.edge_no = k + 1 + LAT;
    sb_q.push_back(e);
    @(negedge clk); dat = 32'd0;
    while (cyc < k + 2 + LAT) @(negedge clk);
    chk("busy_after_resp", 32'(bus8.busy), 32'd0);
    chk("resp_seen", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  vec_t vt[13];

  initial begin
    int k;
    sb_t e;
    vt[0]  = '{4'd1, 32'hFFFF0000, 32'h0000FFFF, 2'd1, 32'hFFFFFFFF};
    vt[1]  = '{4'd1, 32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h00000000};
    vt[2]  = '{4'd2, 32'h00000000, 32'h00000001, 2'd2, 32'h00000000};
    vt[3]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd1, 32'h00000000};
    vt[4]  = '{4'd5, 32'h00000001, 32'd31,       2'd1, 32'h80000000};
    vt[5]  = '{4'd5, 32'hFFFFFFFF, 32'd32,       2'd1, 32'hFFFFFFFF};
    vt[6]  = '{4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd1, 32'h00000001};
    vt[7]  = '{4'd7, 32'h12345678, 32'h00000000, 2'd3, 32'h00000000};
    vt[8]  = '{4'd2, 32'h00000010, 32'h00000003, 2'd1, 32'h0000000D};
    vt[9]  = '{4'd1, 32'h80000000, 32'h80000000, 2'd2, 32'h00000000};
    vt[10] = '{4'd6, 32'h80000000, 32'h00000004, 2'd1, 32'h08000000};
    vt[11] = '{4'd3, 32'hDEADBEEF, 32'h00000001, 2'd3, 32'h00000000};
    vt[12] = '{4'd1, 32'h7FFFFFFF, 32'h80000000, 2'd1, 32'hFFFFFFFF};

    cmd = 4'd0; dat = 32'd0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_resp", 32'(bus8.out_resp), 32'd0);
    chk("rst_data", bus8.out_data, 32'd0);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_drop", 32'(bus8.drop_cnt), 32'd0);
    rst_n = 1'b1;

    // NOP with live data must not start a transaction
    @(negedge clk); cmd = 4'd0; dat = 32'hA5A5A5A5;
    @(negedge clk);
    chk("nop_stays_idle", 32'(bus8.busy), 32'd0);

    for (int i = 0; i < 13; i++)
      run_txn(vt[i].c, vt[i].a, vt[i].b, vt[i].r, vt[i].d);
    chk("no_drops_yet", 32'(bus8.drop_cnt), 32'd0);

    // Command held through OPND2/EXEC/RESP: 4 drops, one response only
    @(negedge clk); cmd = 4'd1; dat = 32'd5;
    @(negedge clk); k = cyc; dat = 32'd6;
    e.resp = 2'd1; e.data = 32'd11; e.edge_no = k + 1 + LAT;
    sb_q.push_back(e);
    while (cyc < k + 4) @(negedge clk);
    cmd = 4'd0; dat = 32'd0;
    while (cyc < k + 5) @(negedge clk);
    chk("drop8_after_hold", 32'(bus8.drop_cnt), 32'd4);
    chk("drop2_saturated", 32'(bus2.drop_cnt), 32'd3);
    chk("hold_resp_seen", 32'(sb_q.size()), 32'd0);
    chk("hold_idle", 32'(bus8.busy), 32'd0);
    @(negedge clk);
    chk("hold_no_second_txn", 32'(bus8.busy), 32'd0);

    // A command sitting on the RESP->IDLE edge is dropped, not accepted
    @(negedge clk); cmd = 4'd2; dat = 32'd9;
    @(negedge clk); k = cyc; cmd = 4'd0; dat = 32'd4;
    e.resp = 2'd1; e.data = 32'd5; e.edge_no = k + 1 + LAT;
    sb_q.push_back(e);
    while (cyc < k + 4) @(negedge clk);
    cmd = 4'd1; dat = 32'd1;
    @(negedge clk); cmd = 4'd0; dat = 32'd0;
    chk("resp_edge_drop8", 32'(bus8.drop_cnt), 32'd5);
    chk("resp_edge_drop2", 32'(bus2.drop_cnt), 32'd3);
    chk("resp_edge_not_taken", 32'(bus8.busy), 32'd0);
    repeat (6) @(negedge clk);
    chk("resp_edge_q_empty", 32'(sb_q.size()), 32'd0);

    // Reset during EXEC: outputs clear immediately, transaction abandoned
    @(negedge clk); cmd = 4'd1; dat = 32'h100;
    @(negedge clk); cmd = 4'd0; dat = 32'h200;
    @(negedge clk); dat = 32'd0;
    @(posedge clk); #2;
    chk("pre_rst_busy", 32'(bus8.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_resp", 32'(bus8.out_resp), 32'd0);
    chk("arst_data", bus8.out_data, 32'd0);
    chk("arst_busy", 32'(bus8.busy), 32'd0);
    chk("arst_drop8", 32'(bus8.drop_cnt), 32'd0);
    chk("arst_drop2", 32'(bus2.drop_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_no_busy", 32'(bus8.busy), 32'd0);
    run_txn(4'd1, 32'h1, 32'h1, 2'd1, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
